// File: rtl/zsdram_pkg.sv
// Shared types and constants for the SDRAM read-back UART dump engine.
package zsdram_pkg;

    localparam int ZS_ADDR_W           = 24;
    localparam int ZS_BAUD_DIV_DEFAULT = 1157;
    localparam int UART_FRAME_BITS     = 10;

    typedef logic [ZS_ADDR_W-1:0] zs_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_TX_HI,
        ST_TX_LO,
        ST_NEXT,
        ST_DONE
    } zs_state_e;

    // Word addresses wrap modulo 2^24 by construction of the type width.
    function automatic zs_addr_t zs_addr_next(input zs_addr_t a);
        return a + zs_addr_t'(1);
    endfunction

endpackage

// File: rtl/zsdram_uart_dump_if.sv
// Read-port handshake between the dump engine and the SDRAM base controller.
interface zsdram_uart_dump_if;
    import zsdram_pkg::*;

    zs_addr_t    oAddr;
    logic [1:0]  oCall;
    logic [1:0]  iDone;
    logic [15:0] iData;

    modport master (
        output oAddr,
        output oCall,
        input  iDone,
        input  iData
    );

    modport slave (
        input  oAddr,
        input  oCall,
        output iDone,
        output iData
    );

endinterface

// File: rtl/zuart_tx_byte.sv
// 8N1 byte serializer; oDone marks the last cycle of the stop bit so a chained
// start issued in that cycle follows with no idle gap. Requires BAUD_DIV >= 2.
module zuart_tx_byte
    import zsdram_pkg::*;
#(
    parameter int BAUD_DIV = ZS_BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iStart,
    input  logic [7:0] iByte,
    output logic       oDone,
    output logic       TXD
);

    localparam int              DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(BAUD_DIV - 2);
    localparam logic [3:0]       BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic             active_q, active_d;
    logic [3:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             done_q, done_d;
    logic             frame_end;

    always_comb begin
        active_d  = active_q;
        bit_d     = bit_q;
        div_d     = div_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        frame_end = active_q && (bit_q == BIT_LAST) && (div_q == DIV_LAST);
        done_d    = active_q && (bit_q == BIT_LAST) && (div_q == DIV_PRE);

        if (iStart && (!active_q || frame_end)) begin
            active_d = 1'b1;
            bit_d    = 4'd0;
            div_d    = '0;
            shift_d  = iByte;
            txd_d    = 1'b0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    // Ones shift in behind the data, so the stop bit falls out naturally.
                    bit_d   = bit_q + 4'd1;
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[7:1]};
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            div_q    <= '0;
            shift_q  <= 8'hFF;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
        end
    end

    assign oDone = done_q;
    assign TXD   = txd_q;

endmodule

// File: rtl/zsdram_uart_dump.sv
// Reads a run of 16-bit SDRAM words through the controller read handshake and
// streams each word out on TXD as two 8N1 bytes, high byte first.
module zsdram_uart_dump
    import zsdram_pkg::*;
#(
    parameter int BAUD_DIV = ZS_BAUD_DIV_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  zs_addr_t         iBaseAddr,
    input  logic [CNT_W-1:0] iCount,
    output logic             oBusy,
    output logic             oDone,
    output logic             TXD,
    zsdram_uart_dump_if.master sd
);

    zs_state_e        state_q, state_d;
    zs_addr_t         addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      word_q, word_d;
    logic             call_q, call_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_done;
    logic             unused_done_hi;

    assign unused_done_hi = sd.iDone[1];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        call_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tx_start = 1'b0;
        tx_byte  = word_q[7:0];

        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    addr_d  = iBaseAddr;
                    cnt_d   = iCount;
                    busy_d  = 1'b1;
                    state_d = (iCount == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                // Request level stays up until the controller answers.
                call_d = !sd.iDone[0];
                if (sd.iDone[0]) begin
                    word_d   = sd.iData;
                    tx_start = 1'b1;
                    tx_byte  = sd.iData[15:8];
                    state_d  = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    tx_byte  = word_q[7:0];
                    state_d  = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                if (tx_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                cnt_d   = cnt_q - CNT_W'(1);
                addr_d  = zs_addr_next(addr_q);
                state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            call_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            call_q  <= call_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    zuart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .iStart (tx_start),
        .iByte  (tx_byte),
        .oDone  (tx_done),
        .TXD    (TXD)
    );

    assign sd.oAddr = addr_q;
    assign sd.oCall = {1'b0, call_q};
    assign oBusy    = busy_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_zsdram_uart_dump.sv
// Bench for zsdram_uart_dump: vector table of dumps, controller model, UART
// receiver monitor and an expected-byte scoreboard.
module tb_zsdram_uart_dump;
    import zsdram_pkg::*;

    localparam int BAUD = 8;

    logic        clk;
    logic        rst;
    logic        iStart;
    zs_addr_t    iBaseAddr;
    logic [15:0] iCount;
    logic        oBusy;
    logic        oDone;
    logic        txd;
    int          cyc = 0;

    zsdram_uart_dump_if sd();

    zsdram_uart_dump #(
        .BAUD_DIV (BAUD),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iStart    (iStart),
        .iBaseAddr (iBaseAddr),
        .iCount    (iCount),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .TXD       (txd),
        .sd        (sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        bit         lo;
    } exp_t;

    typedef struct {
        zs_addr_t    base;
        logic [15:0] count;
        int          poke;
        zs_addr_t    end_addr;
    } vec_t;

    exp_t     exp_q[$];
    zs_addr_t req_q[$];
    bit       wr_seen = 1'b0;
    int       n_checks = 0;
    int       n_pass = 0;
    vec_t     vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Controller model: iDone[0] pulses 5 cycles after the request rises.
    initial begin : ctrl_model
        int wcnt;
        wcnt = 0;
        sd.iDone = 2'b00;
        sd.iData = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                sd.iDone = 2'b00;
                wcnt = 0;
            end else begin
                if (sd.oCall[1]) wr_seen = 1'b1;
                if (sd.iDone[0]) begin
                    sd.iDone = 2'b00;
                end else if (sd.oCall[0]) begin
                    if (wcnt == 0) req_q.push_back(sd.oAddr);
                    wcnt++;
                    if (wcnt == 5) begin
                        sd.iDone = 2'b01;
                        sd.iData = sd.oAddr[15:0] ^ 16'hA5A5;
                        wcnt = 0;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // UART receiver: samples every cycle of each bit so width errors show up.
    initial begin : uart_mon
        int         st;
        int         prev_start;
        logic [7:0] by;
        logic       v;
        bit         shape_ok;
        bit         abort;
        exp_t       e;
        prev_start = -1000;
        forever begin
            @(negedge clk);
            if (!rst && txd == 1'b0) begin
                st = cyc;
                by = 8'h00;
                v = 1'b0;
                shape_ok = 1'b1;
                abort = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < BAUD; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (rst) abort = 1'b1;
                        if (j == 0) begin
                            v = txd;
                            if (k == 9 && v !== 1'b1) shape_ok = 1'b0;
                            if (k >= 1 && k <= 8) by[k-1] = v;
                        end else if (txd !== v) begin
                            shape_ok = 1'b0;
                        end
                    end
                end
                if (!abort) begin
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        $display("frame @%0d byte 0x%02h expected 0x%02h", st, by, e.b);
                        check("byte", 32'(by), 32'(e.b));
                        check("frame_shape", 32'(shape_ok), 32'd1);
                        if (e.lo) check("byte_gap", 32'(st - prev_start), 32'(10 * BAUD));
                    end
                    prev_start = st;
                end
            end
        end
    end

    task automatic push_expected(input zs_addr_t base, input logic [15:0] count);
        zs_addr_t    a;
        logic [15:0] d;
        exp_t        e;
        for (int i = 0; i < int'(count); i++) begin
            a = base + zs_addr_t'(i);
            d = a[15:0] ^ 16'hA5A5;
            e.b = d[15:8]; e.lo = 1'b0; exp_q.push_back(e);
            e.b = d[7:0];  e.lo = 1'b1; exp_q.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int budget;
        int done_c;
        bit got;
        zs_addr_t a;
        req_q.delete();
        push_expected(v.base, v.count);
        budget = 200 * int'(v.count) + 40;
        @(negedge clk);
        iStart = 1'b1; iBaseAddr = v.base; iCount = v.count;
        @(negedge clk);
        iStart = 1'b0; iBaseAddr = 24'hABCDEF; iCount = 16'd7;
        check("busy_after_start", 32'(oBusy), 32'd1);
        check("call_lat1", 32'(sd.oCall), 32'd0);
        @(negedge clk);
        check("call_lat2", 32'(sd.oCall), (v.count != 0) ? 32'd1 : 32'd0);
        got = 1'b0;
        done_c = 0;
        for (int c = 0; c < budget; c++) begin
            if (oDone) begin
                got = 1'b1;
                done_c = c;
                break;
            end
            if (c == v.poke) begin
                iStart = 1'b1; iBaseAddr = 24'h000500; iCount = 16'd5;
            end else begin
                iStart = 1'b0;
            end
            @(negedge clk);
        end
        iStart = 1'b0;
        $display("dump base 0x%06h count %0d: done=%0b reqs=%0d end_addr 0x%06h", v.base, v.count, got, req_q.size(), sd.oAddr);
        check("done_seen", 32'(got), 32'd1);
        if (v.count == 0) check("zero_done_lat", 32'(done_c), 32'd0);
        check("busy_at_done", 32'(oBusy), 32'd0);
        check("end_addr", 32'(sd.oAddr), 32'(v.end_addr));
        check("req_count", 32'(req_q.size()), 32'(v.count));
        for (int i = 0; i < req_q.size() && i < int'(v.count); i++) begin
            a = v.base + zs_addr_t'(i);
            check("req_addr", 32'(req_q[i]), 32'(a));
        end
        check("bytes_all_seen", 32'(exp_q.size()), 32'd0);
        check("write_call_zero", 32'(wr_seen), 32'd0);
        check("txd_idle", 32'(txd), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(oDone), 32'd0);
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vecs[0] = '{base: 24'h000010, count: 16'd1, poke: -1, end_addr: 24'h000011};
        vecs[1] = '{base: 24'h000000, count: 16'd3, poke: -1, end_addr: 24'h000003};
        vecs[2] = '{base: 24'h123456, count: 16'd0, poke: -1, end_addr: 24'h123456};
        vecs[3] = '{base: 24'hFFFFFF, count: 16'd2, poke: -1, end_addr: 24'h000001};
        vecs[4] = '{base: 24'h000100, count: 16'd2, poke: 20, end_addr: 24'h000102};
        vecs[5] = '{base: 24'h0000AB, count: 16'd2, poke: -1, end_addr: 24'h0000AD};

        rst = 1'b1; iStart = 1'b0; iBaseAddr = '0; iCount = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_call", 32'(sd.oCall), 32'd0);
        check("rst_addr", 32'(sd.oAddr), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (3) @(negedge clk);
        end

        // Reset during a data bit of the second byte of a two-word dump.
        req_q.delete();
        push_expected(24'h000040, 16'd2);
        @(negedge clk);
        iStart = 1'b1; iBaseAddr = 24'h000040; iCount = 16'd2;
        @(negedge clk);
        iStart = 1'b0;
        repeat (104) @(negedge clk);
        $display("reset mid-dump at cycle %0d: txd=%0b busy=%0b", cyc, txd, oBusy);
        rst = 1'b1;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_call", 32'(sd.oCall), 32'd0);
        check("midrst_busy", 32'(oBusy), 32'd0);
        check("midrst_done", 32'(oDone), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        req_q.delete();
        repeat (100) @(negedge clk);
        check("post_rst_busy", 32'(oBusy), 32'd0);
        check("post_rst_addr", 32'(sd.oAddr), 32'd0);
        run_vec(vecs[5]);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
